// File: rtl/wb_obi_bridge.sv
// Wishbone classic (single-clock) responder to OBI initiator bridge.
// Each accepted WB cycle becomes exactly one OBI request/response
// transaction, and the bridge returns a single-cycle WB ack. Only one
// transaction is in flight at a time, and every output is registered.
// Optional feature macro: WB_OBI_TIMEOUT_EN. When it is defined, the bridge
// bounds the wait for obi_rvalid_i, answers a timeout with wb_err_o and
// 0xDEADBEEF, and later discards the late response.
module wb_obi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] OBI_BASE_ADDR = '0
`ifdef WB_OBI_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic [DATA_WIDTH-1:0] wb_rdata_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [DATA_WIDTH-1:0] obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0] obi_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  aborted_q, aborted_d;
  logic                  accept;
  logic                  suppress;

`ifdef WB_OBI_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  logic                 err_q, err_d;
  logic                 stale_q, stale_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign accept = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q & ~stale_q;
  assign wb_err_o = err_q;
`else
  assign accept = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_err_o = 1'b0;
`endif

  // A master that has already dropped cyc must not see a response pulse
  assign suppress = aborted_q | ~wb_cyc_i;

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    aborted_d = aborted_q;
`ifdef WB_OBI_TIMEOUT_EN
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    stale_d   = stale_q;
    if (stale_q && obi_rvalid_i) begin
      stale_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        if (accept) begin
          addr_d  = (wb_addr_i + OBI_BASE_ADDR) & ALIGN_MASK;
          we_d    = wb_we_i;
          be_d    = wb_sel_i;
          wdata_d = wb_wdata_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!wb_cyc_i) begin
          aborted_d = 1'b1;
        end
        if (obi_gnt_i) begin
          req_d   = 1'b0;
          state_d = RESP;
`ifdef WB_OBI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RESP: begin
        if (!wb_cyc_i) begin
          aborted_d = 1'b1;
        end
        if (obi_rvalid_i) begin
          rdata_d = obi_rdata_i;
          ack_d   = ~suppress;
          state_d = ACK;
        end
`ifdef WB_OBI_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = ~suppress;
          stale_d = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset silently drops any transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      aborted_q <= 1'b0;
`ifdef WB_OBI_TIMEOUT_EN
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      aborted_q <= aborted_d;
`ifdef WB_OBI_TIMEOUT_EN
      err_q     <= err_d;
      stale_q   <= stale_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign wb_rdata_o  = rdata_q;
  assign wb_ack_o    = ack_q;

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Self-checking bench for wb_obi_bridge.
// A WB master issues directed and random accesses. An OBI slave model
// responds with random grant and response delays. A monitor compares the
// DUT outputs against expectations that the stimulus side queues up.
// Timeout cases are exercised when WB_OBI_TIMEOUT_EN is defined.
module tb_wb_obi_bridge;

  localparam logic [31:0] BASE = 32'h0008_0000;
  localparam int TMO = 8;
  localparam int WAIT_LIMIT = 200;
`ifdef WB_OBI_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum {K_ACK, K_ABORT, K_TMO, K_RST} kind_e;
  typedef enum {P_IDLE, P_WAITG, P_GNTED, P_WAITR, P_LATE, P_HOLD} phase_e;

  typedef struct {
    kind_e kind;
    int    gdelay;
    int    rdelay;
    bit    junk_rv;
  } slv_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_cycles;
  } obi_t;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } wb_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_addr_i, wb_wdata_i;
  logic [31:0] wb_rdata_o;
  logic        wb_ack_o, wb_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;

  int checks = 0;
  int errors = 0;
  int resp_count = 0;

  obi_t   obi_exp[$];
  slv_t   slv_q[$];
  wb_t    wb_exp[$];
  phase_e phase = P_IDLE;
  bit     hold_flag = 1'b0;
  slv_t   slv_cur;
  wb_t    mon_w;
  obi_t   mon_o;
  bit     prev_resp = 1'b0;
  int     req_cycles = 0;

  wb_obi_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .OBI_BASE_ADDR(BASE)
`ifdef WB_OBI_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_addr_i(wb_addr_i), .wb_wdata_i(wb_wdata_i),
    .wb_rdata_o(wb_rdata_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no DUT event within %0d cycles", name, WAIT_LIMIT);
  endtask

  // OBI slave model: drives gnt/rvalid shortly after each rising edge
  initial begin : obi_slave
    int cnt;
    bit do_grant, do_resp;
    wb_t w;
    cnt = 0;
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      obi_gnt_i = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_rdata_i = $urandom;
      do_grant = 1'b0;
      do_resp = 1'b0;
      if (!rst_ni) begin
        phase = P_IDLE;
        hold_flag = 1'b0;
      end else begin
        case (phase)
          P_IDLE: begin
            if (obi_req_o && slv_q.size() != 0) begin
              slv_cur = slv_q[0];
              cnt = slv_cur.gdelay;
              if (cnt == 0) do_grant = 1'b1;
              else phase = P_WAITG;
            end
          end
          P_WAITG: begin
            cnt--;
            if (cnt == 0) do_grant = 1'b1;
          end
          P_GNTED: begin
            slv_cur = slv_q.pop_front();
            if (slv_cur.kind == K_TMO) begin
              w.is_err = 1'b1;
              w.data = 32'hDEAD_BEEF;
              wb_exp.push_back(w);
              cnt = TMO + int'($urandom_range(0, 3));
              phase = P_LATE;
            end else if (slv_cur.kind == K_RST) begin
              phase = P_HOLD;
              hold_flag = 1'b1;
            end else begin
              cnt = slv_cur.rdelay;
              if (cnt == 0) do_resp = 1'b1;
              else phase = P_WAITR;
            end
          end
          P_WAITR: begin
            cnt--;
            if (cnt == 0) do_resp = 1'b1;
          end
          P_LATE: begin
            cnt--;
            if (cnt == 0) begin
              obi_rvalid_i = 1'b1;
              phase = P_IDLE;
            end
          end
          default: begin
          end
        endcase
        if (do_grant) begin
          obi_gnt_i = 1'b1;
          if (slv_cur.junk_rv) obi_rvalid_i = 1'b1;
          phase = P_GNTED;
        end
        if (do_resp) begin
          obi_rvalid_i = 1'b1;
          if (slv_cur.kind == K_ACK) begin
            w.is_err = 1'b0;
            w.data = obi_rdata_i;
            wb_exp.push_back(w);
          end
          phase = P_IDLE;
        end
      end
    end
  end

  // Monitor: compares WB responses and OBI requests against queued expectations
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      req_cycles = 0;
      prev_resp = 1'b0;
    end else begin
      if (wb_ack_o || wb_err_o) begin
        resp_count++;
        checkOutput("resp_pulse_width", 32'(prev_resp), 32'd0);
        if (wb_exp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got ack=%b err=%b expected none", wb_ack_o, wb_err_o);
        end else begin
          mon_w = wb_exp.pop_front();
          checkOutput("wb_err", 32'(wb_err_o), 32'(mon_w.is_err));
          checkOutput("wb_ack", 32'(wb_ack_o), 32'(!mon_w.is_err));
          checkOutput("wb_rdata", wb_rdata_o, mon_w.data);
        end
      end
      prev_resp = wb_ack_o || wb_err_o;
      if (obi_req_o) begin
        if (obi_exp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_req: got req=1 expected 0");
        end else begin
          mon_o = obi_exp[0];
          req_cycles++;
          checkOutput("obi_addr", obi_addr_o, mon_o.addr);
          checkOutput("obi_we", 32'(obi_we_o), 32'(mon_o.we));
          checkOutput("obi_be", 32'(obi_be_o), 32'(mon_o.be));
          checkOutput("obi_wdata", obi_wdata_o, mon_o.wdata);
          if (obi_gnt_i) begin
            checkOutput("obi_req_cycles", 32'(req_cycles), 32'(mon_o.req_cycles));
            void'(obi_exp.pop_front());
            req_cycles = 0;
          end
        end
      end
    end
  end

  // Issue one WB access and queue what the DUT should do with it
  task automatic applyStimulus(input kind_e kind, input logic we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] wdata,
                               input int gd, input int rd, input bit junk, input bit chk_lat);
    obi_t o;
    slv_t s;
    int lat;
    int resp0;
    o.addr = (addr + BASE) & 32'hFFFF_FFFC;
    o.we = we;
    o.be = sel;
    o.wdata = wdata;
    o.req_cycles = gd + 1;
    obi_exp.push_back(o);
    s.kind = kind;
    s.gdelay = gd;
    s.rdelay = rd;
    s.junk_rv = junk;
    slv_q.push_back(s);
    @(negedge clk_i);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = we;
    wb_addr_i = addr;
    wb_sel_i = sel;
    wb_wdata_i = wdata;
    resp0 = resp_count;
    lat = 0;
    if (kind == K_ABORT) begin
      while (!obi_req_o && lat < WAIT_LIMIT) begin
        @(negedge clk_i);
        lat++;
      end
      if (!obi_req_o) reportTimeout("abort_req");
      @(negedge clk_i);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      lat = 0;
      while ((slv_q.size() != 0 || phase != P_IDLE) && lat < WAIT_LIMIT) begin
        @(negedge clk_i);
        lat++;
      end
      repeat (3) @(negedge clk_i);
      checkOutput("abort_no_resp", 32'(resp_count), 32'(resp0));
    end else if (kind == K_RST) begin
      while (!hold_flag && lat < WAIT_LIMIT) begin
        @(negedge clk_i);
        lat++;
      end
      if (!hold_flag) reportTimeout("rst_resp_state");
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_req", 32'(obi_req_o), 32'd0);
      checkOutput("rst_mid_addr", obi_addr_o, 32'd0);
      checkOutput("rst_mid_we", 32'(obi_we_o), 32'd0);
      checkOutput("rst_mid_be", 32'(obi_be_o), 32'd0);
      checkOutput("rst_mid_wdata", obi_wdata_o, 32'd0);
      checkOutput("rst_mid_rdata", wb_rdata_o, 32'd0);
      checkOutput("rst_mid_ack", 32'(wb_ack_o), 32'd0);
      checkOutput("rst_mid_err", 32'(wb_err_o), 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
    end else begin
      do begin
        @(negedge clk_i);
        lat++;
      end while (!(wb_ack_o || wb_err_o) && lat < WAIT_LIMIT);
      if (!(wb_ack_o || wb_err_o)) reportTimeout("wb_resp");
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      if (chk_lat) begin
        if (kind == K_TMO) checkOutput("tmo_latency", 32'(lat), 32'(gd + TMO + 2));
        else checkOutput("ack_latency", 32'(lat), 32'(gd + rd + 3));
      end
    end
  endtask

  // Main stimulus sequence: reset, directed cases, then random traffic
  initial begin : stimulus
    kind_e kind;
    kind_e prev_kind;
    int r;
    logic [31:0] addr;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    wb_sel_i = '0;
    wb_addr_i = '0;
    wb_wdata_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_req", 32'(obi_req_o), 32'd0);
    checkOutput("reset_ack", 32'(wb_ack_o), 32'd0);
    checkOutput("reset_err", 32'(wb_err_o), 32'd0);
    checkOutput("reset_addr", obi_addr_o, 32'd0);
    checkOutput("reset_rdata", wb_rdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    applyStimulus(K_ACK, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 1'b0, 1'b1);
    applyStimulus(K_ACK, 1'b1, 32'h0000_0102, 4'b0011, 32'hA5A5_0001, 4, 1, 1'b0, 1'b1);
    applyStimulus(K_ACK, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0, 1'b1, 1'b1);
    applyStimulus(K_ACK, 1'b0, 32'hFFF8_0000, 4'b0000, 32'h0, 1, 2, 1'b0, 1'b1);
    applyStimulus(K_ABORT, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 2, 1, 1'b0, 1'b0);
    applyStimulus(K_ACK, 1'b0, 32'h0000_0024, 4'hF, 32'h0, 0, 1, 1'b0, 1'b1);
    applyStimulus(K_RST, 1'b0, 32'h0000_0030, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_ACK, 1'b0, 32'h0000_0034, 4'hF, 32'h0, 0, 0, 1'b0, 1'b1);
`ifdef WB_OBI_TIMEOUT_EN
    applyStimulus(K_TMO, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1, 0, 1'b0, 1'b1);
    applyStimulus(K_ACK, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0);
`endif

    prev_kind = K_ACK;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) kind = K_ABORT;
      else if (r == 1 && TMO_EN) kind = K_TMO;
      else kind = K_ACK;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFF8_0000 + $urandom_range(0, 255);
      else addr = $urandom;
      applyStimulus(kind, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0), prev_kind != K_TMO);
      prev_kind = kind;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (20) @(negedge clk_i);
    checkOutput("wb_exp_left", 32'(wb_exp.size()), 32'd0);
    checkOutput("obi_exp_left", 32'(obi_exp.size()), 32'd0);
    checkOutput("slv_q_left", 32'(slv_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wb_obi_bridge.md
Name: wb_obi_bridge

Overview:
Wishbone (classic, single-clock) responder to OBI initiator bridge. It lets an external Wishbone master, such as a debug/loader host, issue word accesses into the SoC's OBI address space (DRAM, IRAM, peripherals). The block converts each WB cycle into exactly one OBI request/response transaction and returns data with a single-cycle WB ack. One transaction is in flight at a time; all outputs are registered.

Parameters:
ADDR_WIDTH, 32, width of WB and OBI address buses
DATA_WIDTH, 32, data bus width; must be 32
OBI_BASE_ADDR, 32'h0000_0000, constant added to the WB address to form the OBI address
TIMEOUT_CYCLES, 255, maximum cycles waiting for obi_rvalid_i (only with WB_OBI_TIMEOUT_EN)

Ports:
clk_i  input  1  clock; both WB and OBI sides are synchronous to it
rst_ni  input  1  asynchronous active-low reset
wb_cyc_i  input  1  WB cycle
wb_stb_i  input  1  WB strobe
wb_we_i  input  1  WB write enable
wb_sel_i  input  4  WB byte select
wb_addr_i  input  ADDR_WIDTH  WB byte address
wb_wdata_i  input  32  WB write data
wb_rdata_o  output  32  WB read data, valid while wb_ack_o or wb_err_o is high
wb_ack_o  output  1  WB acknowledge, one-cycle pulse
wb_err_o  output  1  WB error, one-cycle pulse; tied 0 without WB_OBI_TIMEOUT_EN
obi_req_o  output  1  OBI request
obi_gnt_i  input  1  OBI grant
obi_addr_o  output  ADDR_WIDTH  OBI address, word aligned
obi_we_o  output  1  OBI write enable
obi_be_o  output  4  OBI byte enable
obi_wdata_o  output  32  OBI write data
obi_rvalid_i  input  1  OBI response valid
obi_rdata_i  input  32  OBI read data

Behaviour:
- Reset is asynchronous on rst_ni low. All outputs are driven to 0 and the FSM enters IDLE; reset mid-transaction discards the transaction silently.
- FSM states are IDLE, REQ, RESP, ACK.
- IDLE:
  - Accept when wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o.
  - Latch obi_addr_o = (wb_addr_i + OBI_BASE_ADDR) with bits [1:0] forced to 0. The addition wraps modulo 2^ADDR_WIDTH.
  - Latch obi_we_o = wb_we_i, obi_be_o = wb_sel_i (4'b0000 passes through unchanged), obi_wdata_o = wb_wdata_i.
  - Set obi_req_o = 1 and go to REQ.
- REQ:
  - obi_req_o and all address/control/data outputs are held stable until obi_gnt_i (OBI rule: a request is never retracted).
  - On the gnt cycle, clear obi_req_o at the next edge and go to RESP.
  - Zero-wait gnt means req is high for exactly 1 cycle.
- RESP:
  - Wait for obi_rvalid_i. Any rvalid in the same cycle as gnt is ignored (OBI rvalid arrives at or after the cycle following gnt).
  - On rvalid, register wb_rdata_o = obi_rdata_i for both reads and writes, and go to ACK with wb_ack_o = 1.
- ACK:
  - wb_ack_o is high for exactly one cycle, then returns to IDLE.
  - A request held high during ACK is not re-accepted. A new strobe is sampled in IDLE the cycle after.
- Minimum latency, zero-wait slave: strobe sampled at edge 0, req high in cycle 1, gnt in cycle 1, rvalid in cycle 2, ack high in cycle 3. This is 3 cycles from strobe sample to ack; back-to-back throughput is 1 access per 4 cycles.
- WB abort (wb_cyc_i falls in REQ or RESP):
  - The OBI transaction still completes.
  - An aborted flag is set, and the ack/err pulse for that transaction is suppressed (FSM passes through ACK with outputs low).
  - The flag is cleared in IDLE.
- wb_rdata_o holds its last value outside ack; no bus is driven during IDLE.

Optional Feature:
Macro WB_OBI_TIMEOUT_EN.
- When defined, a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to RESP and increments each cycle without rvalid.
- When it reaches TIMEOUT_CYCLES, go to ACK with wb_err_o = 1 (instead of wb_ack_o) and wb_rdata_o = 32'hDEAD_BEEF.
- A stale_pending flag is then set. The next obi_rvalid_i seen in any state is discarded and clears the flag.
- While stale_pending = 1, IDLE does not accept new requests.
- The REQ state never times out.
- When the macro is undefined, there is no counter, wb_err_o is constant 0, and RESP waits indefinitely.

Test Plan:
- Read, zero-wait: OBI_BASE_ADDR = 0, read 0x0000_0010, gnt in req cycle, rvalid + rdata 0x1234_5678 the next cycle -> obi_addr_o = 0x10, obi_we_o = 0, ack exactly 3 cycles after strobe sample, wb_rdata_o = 0x1234_5678.
- Write with wait states: write 0xA5A5_0001, sel 4'b0011, addr 0x0000_0102, gnt after 4 cycles -> obi_addr_o = 0x100, obi_be_o = 4'b0011, req and outputs stable for 5 cycles, single ack pulse.
- Base offset and wrap: OBI_BASE_ADDR = 0x0008_0000, addr 0x0000_0004 -> obi_addr_o = 0x0008_0004. With addr 0xFFF8_0000 -> obi_addr_o = 0x0000_0000.
- Abort: drop wb_cyc_i in the cycle after req, complete gnt and rvalid -> obi_req_o held until gnt, no wb_ack_o pulse, next request accepted normally.
- Reset mid-op: assert rst_ni low during RESP -> all outputs 0 immediately; after release, a new read completes with correct data.
- Timeout (WB_OBI_TIMEOUT_EN, TIMEOUT_CYCLES = 8): gnt with no rvalid -> wb_err_o pulse after 8 RESP cycles, wb_rdata_o = 0xDEAD_BEEF. A late rvalid is discarded; the following read returns its own data.
